// File: rtl/align_sched_if.sv
// align_sched_if: bundles the input-vector handshake, the two-lane shifter
// port and the aligned-output handshake of align_sched.
//   slave  modport : the scheduler's view (s_* / sh_man_off / m_ready in)
//   master modport : the environment's view (producer, shifter, consumer)
// Lane i of every packed vector sits at [width*i +: width].
interface align_sched_if #(
  parameter int expWidth   = 3,
  parameter int sigWidth   = 3,
  parameter int low_expand = 2,
  parameter int LANES      = 4
);
  localparam int W = sigWidth + 4 + low_expand;

  logic                         s_valid;
  logic                         s_ready;
  logic [LANES-1:0]             s_sign;
  logic [LANES*expWidth-1:0]    s_exp;
  logic [LANES*sigWidth-1:0]    s_man;
  logic [2*expWidth-1:0]        sh_exp_offset;
  logic [2*sigWidth-1:0]        sh_mantissa;
  logic [1:0]                   sh_sign;
  logic [2*W-1:0]               sh_man_off;
  logic                         m_valid;
  logic                         m_ready;
  logic [LANES*W-1:0]           m_aligned;
  logic [expWidth-1:0]          m_max_exp;
  logic                         busy;

  modport slave (
    input  s_valid, s_sign, s_exp, s_man, sh_man_off, m_ready,
    output s_ready, sh_exp_offset, sh_mantissa, sh_sign,
           m_valid, m_aligned, m_max_exp, busy
  );

  modport master (
    output s_valid, s_sign, s_exp, s_man, sh_man_off, m_ready,
    input  s_ready, sh_exp_offset, sh_mantissa, sh_sign,
           m_valid, m_aligned, m_max_exp, busy
  );
endinterface

// File: rtl/align_sched.sv
// align_sched: sequences a shared two-lane mantissa alignment shifter over a
// vector of LANES mini-float operands. A vector is captured on the input
// handshake, its maximum exponent is found in one cycle, then lane pairs are
// sent to the shifter one pair per cycle and the returned words are collected
// into m_aligned, which is presented with the common exponent on the output
// handshake.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   io   - align_sched_if.slave: s_* input vector, sh_* shifter drive and
//          sh_man_off result, m_* aligned output, busy
module align_sched #(
  parameter int expWidth   = 3,
  parameter int sigWidth   = 3,
  parameter int low_expand = 2,
  parameter int LANES      = 4
) (
  input  logic            clk,
  input  logic            rst,
  align_sched_if.slave    io
);
  localparam int W     = sigWidth + 4 + low_expand;
  localparam int BEATS = LANES / 2;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAXEXP = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [LANES-1:0]            sign_q, sign_d;
  logic [LANES*expWidth-1:0]   exp_q, exp_d;
  logic [LANES*sigWidth-1:0]   man_q, man_d;
  logic [expWidth-1:0]         max_exp_q, max_exp_d;
  logic [LANES*W-1:0]          aligned_q, aligned_d;
  logic                        s_ready_q, s_ready_d;
  logic                        m_valid_q, m_valid_d;
  logic                        busy_q, busy_d;
  logic [2*expWidth-1:0]       sh_off_q, sh_off_d;
  logic [2*sigWidth-1:0]       sh_man_q, sh_man_d;
  logic [1:0]                  sh_sign_q, sh_sign_d;
  int                          lane_cap;
  int                          lane_drv;

  // Unsigned maximum over all lane exponents.
  function automatic logic [expWidth-1:0] f_max_exp(input logic [LANES*expWidth-1:0] e);
    logic [expWidth-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (e[expWidth*i +: expWidth] > m) begin
        m = e[expWidth*i +: expWidth];
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  // Next-state, datapath capture and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    man_d     = man_q;
    max_exp_d = max_exp_q;
    aligned_d = aligned_q;
    sh_off_d  = '0;
    sh_man_d  = '0;
    sh_sign_d = 2'b00;
    lane_cap  = 2 * int'(k_q);
    lane_drv  = 0;

    case (state_q)
      IDLE: begin
        if (io.s_valid) begin
          sign_d  = io.s_sign;
          exp_d   = io.s_exp;
          man_d   = io.s_man;
          state_d = MAXEXP;
        end else begin
          state_d = IDLE;
        end
      end
      MAXEXP: begin
        max_exp_d = f_max_exp(exp_q);
        k_d       = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        // The shifter is combinational: its result belongs to the pair
        // driven during this cycle (beat k_q).
        aligned_d[W*lane_cap +: W]     = io.sh_man_off[0 +: W];
        aligned_d[W*(lane_cap+1) +: W] = io.sh_man_off[W +: W];
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (io.m_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shifter drive is registered, so load the pair for the beat about to
    // run; max_exp_d is already valid when leaving MAXEXP.
    if (state_d == SHIFT) begin
      lane_drv = 2 * int'(k_d);
      for (int j = 0; j < 2; j++) begin
        sh_off_d[expWidth*j +: expWidth] = max_exp_d - exp_q[expWidth*(lane_drv+j) +: expWidth];
        sh_man_d[sigWidth*j +: sigWidth] = man_q[sigWidth*(lane_drv+j) +: sigWidth];
        sh_sign_d[j]                     = sign_q[lane_drv+j];
      end
    end else begin
      sh_off_d  = '0;
      sh_man_d  = '0;
      sh_sign_d = 2'b00;
    end

    s_ready_d = (state_d == IDLE);
    m_valid_d = (state_d == DONE);
    busy_d    = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      sign_q    <= '0;
      exp_q     <= '0;
      man_q     <= '0;
      max_exp_q <= '0;
      aligned_q <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      sh_off_q  <= '0;
      sh_man_q  <= '0;
      sh_sign_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      man_q     <= man_d;
      max_exp_q <= max_exp_d;
      aligned_q <= aligned_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      sh_off_q  <= sh_off_d;
      sh_man_q  <= sh_man_d;
      sh_sign_q <= sh_sign_d;
    end
  end

  assign io.s_ready       = s_ready_q;
  assign io.m_valid       = m_valid_q;
  assign io.busy          = busy_q;
  assign io.m_aligned     = aligned_q;
  assign io.m_max_exp     = max_exp_q;
  assign io.sh_exp_offset = sh_off_q;
  assign io.sh_mantissa   = sh_man_q;
  assign io.sh_sign       = sh_sign_q;
endmodule

// File: tb/tb_align_sched.sv
// tb_align_sched: directed testbench for align_sched. A behavioural model of
// the external two-lane shifter answers sh_* combinationally; expected
// results are hand-computed constants.
module tb_align_sched;
  localparam int EW = 3;
  localparam int SW = 3;
  localparam int LE = 2;
  localparam int LN = 4;
  localparam int W  = SW + 4 + LE;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   n;

  logic [LN-1:0]    v_sign [3];
  logic [LN*EW-1:0] v_exp  [3];
  logic [LN*SW-1:0] v_man  [3];
  logic [LN*W-1:0]  v_aln  [3];
  logic [EW-1:0]    v_max  [3];
  int               order  [3];

  align_sched_if #(.expWidth(EW), .sigWidth(SW), .low_expand(LE), .LANES(LN)) bus ();

  align_sched #(.expWidth(EW), .sigWidth(SW), .low_expand(LE), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shifter: {sign, ({001, man, zeros} >> offset)}.
  function automatic logic [W-1:0] shift_model(input logic s, input logic [SW-1:0] m,
                                               input logic [EW-1:0] off);
    logic [W-2:0] base;
    base = {3'b001, m, {LE{1'b0}}};
    return {s, base >> off};
  endfunction

  always_comb begin
    bus.sh_man_off = {shift_model(bus.sh_sign[1], bus.sh_mantissa[2*SW-1:SW], bus.sh_exp_offset[2*EW-1:EW]),
                      shift_model(bus.sh_sign[0], bus.sh_mantissa[SW-1:0],    bus.sh_exp_offset[EW-1:0])};
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int v);
    bus.s_sign = v_sign[v];
    bus.s_exp  = v_exp[v];
    bus.s_man  = v_man[v];
  endtask

  // Cycles from acceptance until m_valid; 20 means it never came.
  task automatic wait_m_valid(output int l);
    l = 1;
    while (bus.m_valid !== 1'b1 && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // vector 0: mixed exponents
    v_sign[0] = 4'b1010;
    v_exp[0]  = {3'd0, 3'd3, 3'd1, 3'd3};
    v_man[0]  = {3'd7, 3'd0, 3'd2, 3'd5};
    v_aln[0]  = {9'h107, 9'h020, 9'h10A, 9'h034};
    v_max[0]  = 3'd3;
    // vector 1: all exponents equal (max code)
    v_sign[1] = 4'b0000;
    v_exp[1]  = {3'd7, 3'd7, 3'd7, 3'd7};
    v_man[1]  = {3'd0, 3'd0, 3'd0, 3'd0};
    v_aln[1]  = {9'h020, 9'h020, 9'h020, 9'h020};
    v_max[1]  = 3'd7;
    // vector 2: max in lanes 0 and 2
    v_sign[2] = 4'b1001;
    v_exp[2]  = {3'd2, 3'd5, 3'd4, 3'd5};
    v_man[2]  = {3'd4, 3'd1, 3'd6, 3'd3};
    v_aln[2]  = {9'h106, 9'h024, 9'h01C, 9'h12C};
    v_max[2]  = 3'd5;
    order = '{0, 2, 1};

    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_sign  = '0;
    bus.s_exp   = '0;
    bus.s_man   = '0;
    tick();
    tick();
    check("rst_s_ready", bus.s_ready, 1'b1);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_aligned", bus.m_aligned, '0);
    check("rst_max_exp", bus.m_max_exp, 3'd0);
    check("rst_sh", {bus.sh_exp_offset, bus.sh_mantissa, bus.sh_sign}, '0);
    rst = 1'b0;
    tick();

    // Basic vector with shifter-drive timing; inputs change after acceptance.
    apply(0);
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    apply(1);
    check("c1_busy", bus.busy, 1'b1);
    check("c1_s_ready", bus.s_ready, 1'b0);
    check("c1_sh", {bus.sh_exp_offset, bus.sh_mantissa, bus.sh_sign}, '0);
    tick();
    check("c2_sh_off", bus.sh_exp_offset, {3'd2, 3'd0});
    check("c2_sh_man", bus.sh_mantissa, {3'd2, 3'd5});
    check("c2_sh_sign", bus.sh_sign, 2'b10);
    tick();
    check("c3_sh_off", bus.sh_exp_offset, {3'd3, 3'd0});
    check("c3_sh_man", bus.sh_mantissa, {3'd7, 3'd0});
    check("c3_sh_sign", bus.sh_sign, 2'b10);
    check("c3_m_valid", bus.m_valid, 1'b0);
    tick();
    check("c4_m_valid", bus.m_valid, 1'b1);
    check("c4_aligned", bus.m_aligned, v_aln[0]);
    check("c4_max_exp", bus.m_max_exp, v_max[0]);
    check("c4_sh", {bus.sh_exp_offset, bus.sh_mantissa, bus.sh_sign}, '0);

    // Backpressure: hold DONE with a competing input offered.
    bus.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_m_valid", bus.m_valid, 1'b1);
      check("bp_aligned", bus.m_aligned, v_aln[0]);
      check("bp_max_exp", bus.m_max_exp, v_max[0]);
      check("bp_s_ready", bus.s_ready, 1'b0);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("hs_m_valid", bus.m_valid, 1'b0);
    check("hs_s_ready", bus.s_ready, 1'b1);
    check("hs_busy", bus.busy, 1'b0);
    tick();
    bus.s_valid = 1'b0;
    check("acc_busy", bus.busy, 1'b1);
    wait_m_valid(lat);
    check("eq_latency", lat, 4);
    check("eq_aligned", bus.m_aligned, v_aln[1]);
    check("eq_max_exp", bus.m_max_exp, v_max[1]);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;

    // Reset in the first SHIFT cycle discards the vector.
    apply(0);
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    tick();
    check("rs_sh_man", bus.sh_mantissa, {3'd2, 3'd5});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_busy", bus.busy, 1'b0);
    check("rs_s_ready", bus.s_ready, 1'b1);
    check("rs_aligned", bus.m_aligned, '0);
    check("rs_m_valid", bus.m_valid, 1'b0);
    check("rs_sh", {bus.sh_exp_offset, bus.sh_mantissa, bus.sh_sign}, '0);
    apply(2);
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    wait_m_valid(lat);
    check("rs2_latency", lat, 4);
    check("rs2_aligned", bus.m_aligned, v_aln[2]);
    check("rs2_max_exp", bus.m_max_exp, v_max[2]);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;

    // Back-to-back: one result every five cycles, no lane mixing.
    apply(0);
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    apply(2);
    n = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (bus.m_valid === 1'b1) begin
        if (n < 3) begin
          check("b2b_cycle", cyc, 4 + 5 * n);
          check("b2b_aligned", bus.m_aligned, v_aln[order[n]]);
          check("b2b_max_exp", bus.m_max_exp, v_max[order[n]]);
        end
        n++;
      end
      if (cyc == 6) begin
        apply(1);
      end
      tick();
    end
    bus.s_valid = 1'b0;
    check("b2b_count", n, 3);
    tick();
    bus.m_ready = 1'b0;
    check("end_busy", bus.busy, 1'b0);
    check("end_m_valid", bus.m_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
